// File: rtl/arcade_rom_loader.sv
// arcade_rom_loader: ROM download front-end for Arcade cores.
// Takes the data_io ioctl byte stream, keeps only bytes for ROM_INDEX, buffers
// them in a small FIFO and writes each byte to the RAM port using a toggle
// handshake. It also owns the core reset sequence: the sticky loaded flag,
// user reset, and a reset hold that runs after the download has drained.
//
// Ports:
//   clk_sys, reset_n         system clock, synchronous active-low reset
//   ioctl_download/index     download in progress / download target
//   ioctl_wr/addr/dout       byte strobe (rising edge counts), address, data
//   user_reset               status reset bit OR reset button
//   ram_req/ram_ack          toggle handshake; done when ram_ack == ram_req
//   ram_we/addr/din/ds       write enable, word address, replicated byte, strobes
//   rom_loaded               sticky, a ROM download has completed
//   core_reset               active-high reset to the game core
//   overflow                 sticky, a byte was dropped on a full FIFO
//   busy                     FIFO non-empty or write outstanding
//   checksum                 (ARCADE_ROM_LOADER_CHECKSUM_EN only) 16-bit sum of
//                            accepted bytes, cleared at each download start
//
// Optional feature macro: ARCADE_ROM_LOADER_CHECKSUM_EN

module arcade_rom_loader #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_reset,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_ds,
  output logic              rom_loaded,
  output logic              core_reset,
  output logic              overflow,
`ifdef ARCADE_ROM_LOADER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              busy
);

  localparam int unsigned IDX_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W   = IDX_W + 1;
  localparam int unsigned HOLD_W  = $clog2(RESET_HOLD + 1);
  localparam int unsigned ENTRY_W = 25 + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t               state;
  logic                 wr_q;
  logic                 dl_q;
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic                 idx_match;
  logic                 accept;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 txn_done;
  logic                 dl_fall;
  logic                 busy_nxt;
  logic [PTR_W-1:0]     wptr_nxt;
  logic [PTR_W-1:0]     rptr_nxt;
  logic [ENTRY_W-1:0]   head;
  logic [24:0]          head_addr;
  logic [7:0]           head_data;

  // Strobe qualification, FIFO status and next-cycle busy
  always_comb begin
    idx_match  = (ioctl_index == ROM_INDEX);
    accept     = ioctl_wr & ~wr_q & ioctl_download & idx_match;
    fifo_empty = (wptr == rptr);
    fifo_full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
    pop        = (state == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte
    push       = accept && (!fifo_full || pop);
    txn_done   = (state == ST_WAIT) && (ram_ack == ram_req);
    dl_fall    = dl_q & ~ioctl_download & idx_match;
    wptr_nxt   = wptr + PTR_W'(push);
    rptr_nxt   = rptr + PTR_W'(pop);
    head       = fifo_mem[rptr[IDX_W-1:0]];
    head_addr  = head[ENTRY_W-1:8];
    head_data  = head[7:0];
    // busy is registered but tracks the decode of the next-cycle state exactly
    busy_nxt   = (wptr_nxt != rptr_nxt) ||
                 ((state == ST_IDLE) ? !fifo_empty : !txn_done);
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wptr[IDX_W-1:0]] <= {ioctl_addr, ioctl_dout};
  end

  // Write FSM, FIFO pointers and core reset sequencing
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      // Edge detectors start from the live inputs so held levels do not fire
      wr_q       <= ioctl_wr;
      dl_q       <= ioctl_download;
      wptr       <= '0;
      rptr       <= '0;
      busy       <= 1'b0;
      ram_req    <= ram_ack;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_ds     <= '0;
      rom_loaded <= 1'b0;
      overflow   <= 1'b0;
      core_reset <= 1'b1;
      hold_cnt   <= HOLD_W'(RESET_HOLD);
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
      busy <= busy_nxt;

      if (accept && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            ram_addr <= ADDR_W'(head_addr >> 1);
            ram_din  <= {head_data, head_data};
            ram_ds   <= {head_addr[0], ~head_addr[0]};
            ram_we   <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ram_req <= ~ram_req;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (txn_done) begin
            ram_we <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Hold only counts once the FIFO has drained
      if (dl_fall) begin
        rom_loaded <= 1'b1;
        hold_cnt   <= HOLD_W'(RESET_HOLD);
      end else if (!busy && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      core_reset <= user_reset | ~rom_loaded | (ioctl_download & idx_match) |
                    (hold_cnt != '0);
    end
  end

`ifdef ARCADE_ROM_LOADER_CHECKSUM_EN
  logic dl_rise;
  assign dl_rise = ~dl_q & ioctl_download & idx_match;

  // Sum of bytes that actually entered the FIFO; a byte landing on the start edge counts
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (dl_rise) begin
      checksum <= push ? 16'(ioctl_dout) : 16'h0000;
    end else if (push) begin
      checksum <= checksum + 16'(ioctl_dout);
    end
  end
`endif

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Self-checking bench for arcade_rom_loader: directed ioctl strobes, a toggle
// acknowledge responder, and a transaction-level model of the expected writes.
module tb_arcade_rom_loader;

  localparam int unsigned ADDR_W     = 22;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  ROM_INDEX  = 8'h00;
  localparam int unsigned RESET_HOLD = 16;

  logic              clk_sys;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              user_reset;
  logic              ram_req;
  logic              ram_ack;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic [1:0]        ram_ds;
  logic              rom_loaded;
  logic              core_reset;
  logic              overflow;
  logic              busy;
`ifdef ARCADE_ROM_LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  arcade_rom_loader #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
    .ROM_INDEX(ROM_INDEX), .RESET_HOLD(RESET_HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .user_reset(user_reset),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_ds(ram_ds),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow),
`ifdef ARCADE_ROM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .busy(busy)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       din;
    logic [1:0]        ds;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  cap[$];
  int   n_chk;
  int   n_pass;
  int   n_acc;
  int   n_acked;
  int   n_toggles;
  bit   model_ovf;
  bit   mon_en;
  bit   resp_en;
  bit   ack_freeze;
  int   ack_delay;
  logic last_req;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected RAM write for a byte: word address, byte on both lanes, lane strobe
  function automatic wr_t make_exp(input logic [24:0] a, input logic [7:0] d);
    wr_t r;
    r.addr = ADDR_W'(a / 2);
    r.din  = 16'(d) * 16'h0101;
    r.ds   = (a % 2 == 1) ? 2'b10 : 2'b01;
    return r;
  endfunction

  // Model: a byte for the ROM index is kept while fewer than FIFO_DEPTH+1 are unacknowledged
  task automatic model_strobe(input logic [24:0] a, input logic [7:0] d);
    if (ioctl_download && ioctl_index == ROM_INDEX) begin
      if (n_acc - n_acked >= int'(FIFO_DEPTH) + 1) model_ovf = 1'b1;
      else begin
        exp_q.push_back(make_exp(a, d));
        n_acc++;
      end
    end
  endtask

  // One level-held strobe; lat = cycles from the accept edge to the ram_req toggle
  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit end_dl,
                        output int lat);
    logic req0;
    @(negedge clk_sys);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    req0       = ram_req;
    lat        = 0;
    model_strobe(a, d);
    if (end_dl) begin
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk_sys);
        if (lat == 0 && ram_req !== req0) lat = k;
      end
      ioctl_wr = 1'b0;
      repeat (2) @(negedge clk_sys);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk_sys);
      if (!busy && ram_req === ram_ack) done = 1'b1;
    end
    if (!done) chk(name, {30'd0, busy, ram_req ^ ram_ack}, 32'd0);
  endtask

  // Acknowledge responder: answers each request ack_delay cycles after seeing it
  initial begin
    int cnt;
    ram_ack = 1'b1;
    cnt     = 0;
    forever begin
      @(negedge clk_sys);
      if (resp_en && !ack_freeze && ram_req !== ram_ack) begin
        if (cnt + 1 >= ack_delay) begin
          ram_ack = ram_req;
          n_acked++;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Compare process: every ram_req toggle must carry the next modelled write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        if (ram_req !== last_req) begin
          n_toggles++;
          cap.push_back('{addr: ram_addr, din: ram_din, ds: ram_ds});
          if (exp_q.size() == 0) chk("unexpected_write", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("ram_addr", ram_addr, e.addr);
            chk("ram_din", ram_din, e.din);
            chk("ram_ds", ram_ds, e.ds);
            chk("ram_we", ram_we, 1);
          end
        end
        last_req = ram_req;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, t0, s, fall_n, diff;
    logic prev_busy;
    logic [5:0] cr;
    n_chk = 0; n_pass = 0; n_acc = 0; n_acked = 0; n_toggles = 0;
    model_ovf = 0; mon_en = 0; resp_en = 0; ack_freeze = 0; ack_delay = 2;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0; user_reset = 1'b0;

    // Reset with ram_ack high: ram_req must resynchronise to it
    repeat (3) @(negedge clk_sys);
    chk("rst_ram_req", ram_req, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_ds", ram_ds, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    reset_n  = 1'b1;
    last_req = ram_req;
    mon_en   = 1'b1;
    resp_en  = 1'b1;

    // Foreign index and strobes outside a download are ignored
    t0 = n_toggles;
    ioctl_index = 8'h01; ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) strobe(25'(i), 8'(8'h30 + i), 1'b0, lat);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    ioctl_index = 8'h00;
    strobe(25'h10, 8'h77, 1'b0, lat);
    repeat (4) @(negedge clk_sys);
    chk("idx1_toggles", n_toggles - t0, 0);
    chk("idx1_rom_loaded", rom_loaded, 0);
    chk("idx1_core_reset", core_reset, 1);
    chk("idx1_busy", busy, 0);

    // Two bytes at index 0, first one with the latency check
    t0 = n_toggles;
    s  = cap.size();
    ioctl_download = 1'b1;
    strobe(25'h0, 8'hA5, 1'b0, lat);
    chk("latency", lat, 3);
    strobe(25'h1, 8'h5A, 1'b0, lat);
    wait_idle("idle_timeout_b");
    chk("b_toggles", n_toggles - t0, 2);
    if (cap.size() >= s + 2) begin
      chk("b0_addr", cap[s].addr, 0);
      chk("b0_din", cap[s].din, 16'hA5A5);
      chk("b0_ds", cap[s].ds, 2'b01);
      chk("b1_addr", cap[s+1].addr, 0);
      chk("b1_din", cap[s+1].din, 16'h5A5A);
      chk("b1_ds", cap[s+1].ds, 2'b10);
    end else chk("b_capture_count", cap.size(), s + 2);
    chk("b_core_reset", core_reset, 1);

    // Acknowledge held for 40 cycles while 6 bytes arrive: one in flight, 4 buffered, 1 dropped
    t0 = n_toggles;
    ack_freeze = 1'b1;
    for (int i = 0; i < 6; i++) begin
      strobe(25'(2 + i), 8'(8'h10 + i), 1'b0, lat);
      if (i == 4) chk("ovf_after5", overflow, model_ovf);
    end
    chk("ovf_after6", overflow, model_ovf);
    chk("ovf_model_pin", overflow, 1);
    repeat (4) @(negedge clk_sys);
    ack_freeze = 1'b0;
    wait_idle("idle_timeout_c");
    chk("c_toggles", n_toggles - t0, 5);
    chk("c_queue_drained", exp_q.size(), 0);

    // Four bytes, download ends with the FIFO still busy; measure the reset hold
    strobe(25'h100, 8'h11, 1'b0, lat);
    strobe(25'h101, 8'h22, 1'b0, lat);
    strobe(25'h102, 8'h33, 1'b0, lat);
    strobe(25'h103, 8'h44, 1'b1, lat);
    prev_busy = busy;
    fall_n = -1;
    diff   = -1;
    for (int n = 0; n < 300 && diff < 0; n++) begin
      @(negedge clk_sys);
      if (prev_busy && !busy) fall_n = n;
      if (!core_reset && fall_n >= 0) diff = n - fall_n;
      prev_busy = busy;
    end
    chk("hold_cycles", diff, RESET_HOLD + 1);
    chk("d_rom_loaded", rom_loaded, 1);
    chk("d_busy", busy, 0);
    chk("d_overflow_sticky", overflow, 1);
    chk("d_queue_drained", exp_q.size(), 0);

    // User reset pulse of 3 cycles appears one cycle later on core_reset
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_sys);
      cr[k] = core_reset;
      if (k == 0) user_reset = 1'b1;
      if (k == 3) user_reset = 1'b0;
    end
    chk("ureset_pattern", {26'd0, cr}, 32'b001110);

`ifdef ARCADE_ROM_LOADER_CHECKSUM_EN
    // Checksum of 0xFF,0xFF,0x02 then cleared by the next download start
    ioctl_download = 1'b1;
    strobe(25'h200, 8'hFF, 1'b0, lat);
    strobe(25'h201, 8'hFF, 1'b0, lat);
    strobe(25'h202, 8'h02, 1'b0, lat);
    wait_idle("idle_timeout_f");
    chk("checksum_sum", checksum, 16'h0200);
    ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("checksum_frozen", checksum, 16'h0200);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("checksum_clear", checksum, 16'h0000);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
